can_rx_sequencer: RTL and testbench

Receive-path controller for the CAN frame capture block. It recovers bit timing from the raw bus, drives the capture block's `rst`/`en`, removes stuff bits and checks the CRC-15. It also applies an acceptance filter, requests the ACK slot, and hands accepted frames to the host through a one-entry valid/ready output register. It sits between the bus pin synchronizer and the capture block, with the host-side frame consumer downstream.

---
 rtl/can_rx_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_can_rx_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_rx_sequencer.sv
// CAN receive-path sequencer: bit timing recovery, destuffing, CRC-15 check,
// acceptance filtering, ACK request and a one-entry valid/ready frame register.
module can_rx_sequencer #(
    parameter int          BIT_TICKS    = 16,
    parameter int          SAMPLE_POINT = 11,
    parameter logic [29:0] ACC_ID       = 30'h0,
    parameter logic [29:0] ACC_MASK     = 30'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        rx_sync,
    output logic        cap_rst,
    output logic        cap_en,
    output logic        cap_ack,
    input  logic        cap_done,
    input  logic        cap_run_crc,
    input  logic [29:0] cap_address,
    input  logic [3:0]  cap_dlc,
    input  logic [63:0] cap_payload,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [29:0] frame_id,
    output logic [3:0]  frame_dlc,
    output logic [63:0] frame_data,
    output logic        overrun,
    output logic        err_stuff,
    output logic        err_crc
);

    localparam int TW = $clog2(BIT_TICKS);
    localparam int IW = $clog2(11 * BIT_TICKS);
    localparam logic [TW-1:0] TICK_MAX = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] TICK_SP  = TW'(SAMPLE_POINT);
    localparam logic [IW-1:0] IDLE_MAX = IW'(11 * BIT_TICKS - 1);

    typedef enum logic [1:0] {BUS_WAIT = 2'd0, IDLE = 2'd1, RECV = 2'd2, ABORT = 2'd3} state_t;

    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
        return {crc[13:0], 1'b0} ^ ((b ^ crc[14]) ? 15'h4599 : 15'h0000);
    endfunction

    state_t        state_r, state_s;
    logic          sync1_r, rx_prev_r;
    logic [TW-1:0] tick_r, tick_s;
    logic [IW-1:0] idle_cnt_r, idle_cnt_s;
    logic [14:0]   crc_r, crc_s;
    logic [2:0]    run_r, run_s;
    logic          last_bit_r, last_bit_s;
    logic          win_r, win_s;
    logic          seen_crc_r, seen_crc_s;
    logic          cap_en_s, ack_set_s, err_stuff_s, err_crc_s, done_s, load_s, drop_s;
    logic          fall_s, accept_s;
    logic [3:0]    dlc_clamp_s;

    assign fall_s      = rx_prev_r & ~rx_sync;
    assign accept_s    = (((cap_address ^ ACC_ID) & ACC_MASK) == 30'h0);
    assign dlc_clamp_s = (cap_dlc > 4'd8) ? 4'd8 : cap_dlc;

    // Next-state: bus idle detection, bit timing, destuffing and CRC tracking
    always_comb begin
        state_s     = state_r;
        tick_s      = tick_r;
        idle_cnt_s  = idle_cnt_r;
        crc_s       = crc_r;
        run_s       = run_r;
        last_bit_s  = last_bit_r;
        win_s       = win_r;
        seen_crc_s  = seen_crc_r;
        cap_en_s    = 1'b0;
        ack_set_s   = 1'b0;
        err_stuff_s = 1'b0;
        err_crc_s   = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            BUS_WAIT: begin
                if (!rx_sync) begin
                    idle_cnt_s = '0;
                end else if (idle_cnt_r == IDLE_MAX) begin
                    idle_cnt_s = '0;
                    state_s    = IDLE;
                end else begin
                    idle_cnt_s = idle_cnt_r + IW'(1);
                end
            end
            IDLE: begin
                if (fall_s) begin
                    state_s    = RECV;
                    tick_s     = '0;
                    crc_s      = 15'h0000;
                    run_s      = 3'd0;
                    last_bit_s = 1'b0;
                    win_s      = 1'b1;
                    seen_crc_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RECV: begin
                if ((fall_s && (tick_r > TICK_SP)) || (tick_r == TICK_MAX)) begin
                    tick_s = '0;
                end else begin
                    tick_s = tick_r + TW'(1);
                end
                if (tick_r == TICK_SP) begin
                    // Stuff check has priority: a stuff bit may trail the last CRC bit
                    if (win_r && (run_r == 3'd5)) begin
                        if (rx_sync == last_bit_r) begin
                            err_stuff_s = 1'b1;
                            state_s     = ABORT;
                        end else begin
                            run_s      = 3'd1;
                            last_bit_s = rx_sync;
                        end
                    end else if (win_r && seen_crc_r && !cap_run_crc) begin
                        win_s = 1'b0;
                        if (crc_r != 15'h0000) begin
                            err_crc_s = 1'b1;
                            state_s   = ABORT;
                        end else begin
                            cap_en_s  = 1'b1;
                            ack_set_s = accept_s;
                        end
                    end else begin
                        cap_en_s = 1'b1;
                        if (win_r) begin
                            run_s      = ((rx_sync == last_bit_r) && (run_r != 3'd0)) ? run_r + 3'd1 : 3'd1;
                            last_bit_s = rx_sync;
                            if (cap_run_crc) begin
                                seen_crc_s = 1'b1;
                                crc_s      = crc15_step(crc_r, rx_sync);
                            end else begin
                                crc_s = crc_r;
                            end
                        end else begin
                            run_s = run_r;
                        end
                        if (cap_done) begin
                            done_s  = 1'b1;
                            state_s = IDLE;
                        end else begin
                            state_s = RECV;
                        end
                    end
                end else begin
                    state_s = RECV;
                end
            end
            ABORT: begin
                state_s    = BUS_WAIT;
                idle_cnt_s = '0;
            end
            default: begin
                state_s = BUS_WAIT;
            end
        endcase
        load_s = done_s & cap_ack & (~frame_valid | frame_ready);
        drop_s = done_s & cap_ack & frame_valid & ~frame_ready;
    end

    // Synchronizer, FSM state and receive tracking registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev_r  <= 1'b1;
            state_r    <= BUS_WAIT;
            tick_r     <= '0;
            idle_cnt_r <= '0;
            crc_r      <= 15'h0000;
            run_r      <= 3'd0;
            last_bit_r <= 1'b0;
            win_r      <= 1'b0;
            seen_crc_r <= 1'b0;
        end else begin
            sync1_r    <= rx;
            rx_sync    <= sync1_r;
            rx_prev_r  <= rx_sync;
            state_r    <= state_s;
            tick_r     <= tick_s;
            idle_cnt_r <= idle_cnt_s;
            crc_r      <= crc_s;
            run_r      <= run_s;
            last_bit_r <= last_bit_s;
            win_r      <= win_s;
            seen_crc_r <= seen_crc_s;
        end
    end

    // Registered capture controls, error pulses and the output frame register
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_rst     <= 1'b1;
            cap_en      <= 1'b0;
            cap_ack     <= 1'b0;
            err_stuff   <= 1'b0;
            err_crc     <= 1'b0;
            overrun     <= 1'b0;
            frame_valid <= 1'b0;
            frame_id    <= 30'h0;
            frame_dlc   <= 4'd0;
            frame_data  <= 64'h0;
        end else begin
            cap_rst   <= (state_s != RECV);
            cap_en    <= cap_en_s;
            cap_ack   <= (state_s == RECV) && (cap_ack || ack_set_s);
            err_stuff <= err_stuff_s;
            err_crc   <= err_crc_s;
            overrun   <= overrun | drop_s;
            if (load_s) begin
                frame_valid <= 1'b1;
                frame_id    <= cap_address;
                frame_dlc   <= dlc_clamp_s;
                frame_data  <= cap_payload;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_can_rx_sequencer.sv
// Directed bench: a bench-side CAN transmitter/capture model drives two sequencers
// (accept-all and exact-ID filter) and checks frames, errors and the output handshake.
module tb_can_rx_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rx, frame_ready;
    logic        cap_done, cap_run_crc;
    logic [29:0] cap_address;
    logic [3:0]  cap_dlc;
    logic [63:0] cap_payload;

    logic        rx_sync, cap_rst, cap_en, cap_ack, frame_valid, overrun, err_stuff, err_crc;
    logic [29:0] frame_id;
    logic [3:0]  frame_dlc;
    logic [63:0] frame_data;

    logic        rx_sync_1, cap_rst_1, cap_en_1, cap_ack_1, frame_valid_1, overrun_1, err_stuff_1, err_crc_1;
    logic [29:0] frame_id_1;
    logic [3:0]  frame_dlc_1;
    logic [63:0] frame_data_1;

    can_rx_sequencer dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_sync(rx_sync), .cap_rst(cap_rst), .cap_en(cap_en),
        .cap_ack(cap_ack), .cap_done(cap_done), .cap_run_crc(cap_run_crc), .cap_address(cap_address),
        .cap_dlc(cap_dlc), .cap_payload(cap_payload), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_id(frame_id), .frame_dlc(frame_dlc), .frame_data(frame_data), .overrun(overrun),
        .err_stuff(err_stuff), .err_crc(err_crc)
    );

    can_rx_sequencer #(.ACC_ID({11'h124, 1'b0, 18'h0}), .ACC_MASK(30'h3FFF_FFFF)) dut_flt (
        .clk(clk), .rst(rst), .rx(rx), .rx_sync(rx_sync_1), .cap_rst(cap_rst_1), .cap_en(cap_en_1),
        .cap_ack(cap_ack_1), .cap_done(cap_done), .cap_run_crc(cap_run_crc), .cap_address(cap_address),
        .cap_dlc(cap_dlc), .cap_payload(cap_payload), .frame_valid(frame_valid_1), .frame_ready(1'b1),
        .frame_id(frame_id_1), .frame_dlc(frame_dlc_1), .frame_data(frame_data_1), .overrun(overrun_1),
        .err_stuff(err_stuff_1), .err_crc(err_crc_1)
    );

    // Capture-block model: counts non-stuff bits of the current frame
    int cap_cnt = 0;
    int cur_len = 0;
    always @(posedge clk) begin
        if (cap_rst) cap_cnt <= 0;
        else if (cap_en) cap_cnt <= cap_cnt + 1;
    end
    assign cap_run_crc = (cap_cnt < cur_len);
    assign cap_done    = (cap_cnt >= cur_len + 12);

    // Event counters sampled mid-cycle
    int n_en = 0, n_es = 0, n_ec = 0, n_ack = 0, n_ack1 = 0, n_val1 = 0, n_es1 = 0, n_ec1 = 0;
    always @(negedge clk) begin
        n_en   <= n_en + int'(cap_en);
        n_es   <= n_es + int'(err_stuff);
        n_ec   <= n_ec + int'(err_crc);
        n_ack  <= n_ack + int'(cap_ack);
        n_ack1 <= n_ack1 + int'(cap_ack_1);
        n_val1 <= n_val1 + int'(frame_valid_1);
        n_es1  <= n_es1 + int'(err_stuff_1);
        n_ec1  <= n_ec1 + int'(err_crc_1);
    end

    int   n_cmp = 0, n_bad = 0;
    bit   tx_q[$];
    int   ack_idx;
    logic ack_slot0, ack_slot1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Builds the stuffed bit stream of a standard data frame and sets the capture fields
    task automatic build(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data, input bit flip_crc);
        bit          raw[$];
        logic [14:0] crc;
        int          nb, run;
        bit          last;
        nb = (dlc > 4'd8) ? 8 : int'(dlc);
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        repeat (3) raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        for (int i = 0; i < nb * 8; i++) raw.push_back(data[63-i]);
        crc = 15'h0000;
        foreach (raw[k]) crc = {crc[13:0], 1'b0} ^ ((raw[k] ^ crc[14]) ? 15'h4599 : 15'h0000);
        if (flip_crc) crc[7] = ~crc[7];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        tx_q.delete();
        run  = 0;
        last = 1'b0;
        foreach (raw[k]) begin
            tx_q.push_back(raw[k]);
            run  = (run > 0 && raw[k] == last) ? run + 1 : 1;
            last = raw[k];
            if (run == 5) begin
                tx_q.push_back(~last);
                last = ~last;
                run  = 1;
            end
        end
        tx_q.push_back(1'b1);
        ack_idx = tx_q.size();
        tx_q.push_back(1'b0);
        repeat (11) tx_q.push_back(1'b1);
        cur_len     = raw.size();
        cap_address = {id, 1'b0, 18'h0};
        cap_dlc     = dlc;
        cap_payload = data;
    endtask

    // Sends nbits of tx_q (all if negative); optional mid-frame reset or ready pulse on the last sample
    task automatic send(input int nbits, input int rst_bit, input bit ready_last);
        int lim;
        lim = (nbits < 0) ? tx_q.size() : nbits;
        for (int b = 0; b < lim; b++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                if (j == 0) rx = tx_q[b];
                if (b == ack_idx && j == 15) begin
                    ack_slot0 = cap_ack;
                    ack_slot1 = cap_ack_1;
                end
                if (ready_last && b == lim - 1) frame_ready = (j == 14);
                if (b == rst_bit && j == 5) rst = 1'b1;
                if (b == rst_bit && j == 6) begin
                    rst = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic idle_bits(input int n);
        @(negedge clk);
        rx = 1'b1;
        repeat (n * 16 - 1) @(negedge clk);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        check_eq(tag, frame_valid, 1'b0);
    endtask

    int e0, s0, c0, a0, a1, v1, se1, ce1;

    initial begin
        rst = 1'b1; rx = 1'b1; frame_ready = 1'b0;
        cap_address = 30'h0; cap_dlc = 4'd0; cap_payload = 64'h0;
        ack_slot0 = 1'b0; ack_slot1 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_cap_rst", cap_rst, 1'b1);
        check_eq("rst_cap_en", cap_en, 1'b0);
        check_eq("rst_cap_ack", cap_ack, 1'b0);
        check_eq("rst_valid", frame_valid, 1'b0);
        check_eq("rst_id", frame_id, 30'h0);
        check_eq("rst_dlc", frame_dlc, 4'd0);
        check_eq("rst_data", frame_data, 64'h0);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_err_stuff", err_stuff, 1'b0);
        check_eq("rst_err_crc", err_crc, 1'b0);
        rst = 1'b0;
        idle_bits(12);

        // Basic frame ID 0x123, DLC 2, data AB CD
        build(11'h123, 4'd2, 64'hABCD_0000_0000_0000, 1'b0);
        e0 = n_en;
        send(-1, -1, 1'b0);
        settle();
        check_eq("t1_ack_slot", ack_slot0, 1'b1);
        check_eq("t1_cap_en_count", n_en - e0, 63);
        check_eq("t1_valid", frame_valid, 1'b1);
        check_eq("t1_id", frame_id, {11'h123, 1'b0, 18'h0});
        check_eq("t1_dlc", frame_dlc, 4'd2);
        check_eq("t1_data", frame_data, 64'hABCD_0000_0000_0000);
        check_eq("t1_no_err", n_es + n_ec, 0);
        consume("t1_consume");

        // Six dominant bits in the ID
        build(11'h000, 4'd0, 64'h0, 1'b0);
        tx_q[5] = 1'b0;
        s0 = n_es;
        send(12, -1, 1'b0);
        settle();
        check_eq("t2_err_stuff_pulse", n_es - s0, 1);
        check_eq("t2_cap_rst", cap_rst, 1'b1);
        check_eq("t2_valid", frame_valid, 1'b0);
        idle_bits(5);
        build(11'h055, 4'd1, 64'h5A00_0000_0000_0000, 1'b0);
        a0 = n_ack;
        send(-1, -1, 1'b0);
        settle();
        check_eq("t2_early_frame_ignored", frame_valid, 1'b0);
        check_eq("t2_early_frame_no_ack", n_ack - a0, 0);
        idle_bits(12);
        send(-1, -1, 1'b0);
        settle();
        check_eq("t2_recover_valid", frame_valid, 1'b1);
        check_eq("t2_recover_id", frame_id, {11'h055, 1'b0, 18'h0});
        check_eq("t2_recover_data", frame_data, 64'h5A00_0000_0000_0000);
        consume("t2_consume");

        // One CRC bit flipped
        build(11'h123, 4'd2, 64'hABCD_0000_0000_0000, 1'b1);
        c0 = n_ec; a0 = n_ack; s0 = n_es;
        send(-1, -1, 1'b0);
        settle();
        check_eq("t3_err_crc_pulse", n_ec - c0, 1);
        check_eq("t3_no_stuff_err", n_es - s0, 0);
        check_eq("t3_no_ack", n_ack - a0, 0);
        check_eq("t3_valid", frame_valid, 1'b0);
        idle_bits(12);

        // Exact-ID filter for 0x124: reject 0x123, accept 0x124
        build(11'h123, 4'd2, 64'hABCD_0000_0000_0000, 1'b0);
        a1 = n_ack1; v1 = n_val1; se1 = n_es1; ce1 = n_ec1;
        send(-1, -1, 1'b0);
        settle();
        check_eq("t4_flt_ack_slot", ack_slot1, 1'b0);
        check_eq("t4_flt_no_ack", n_ack1 - a1, 0);
        check_eq("t4_flt_no_valid", n_val1 - v1, 0);
        check_eq("t4_flt_no_err", (n_es1 - se1) + (n_ec1 - ce1), 0);
        check_eq("t4_open_valid", frame_valid, 1'b1);
        consume("t4_consume_a");
        build(11'h124, 4'd1, 64'h7700_0000_0000_0000, 1'b0);
        v1 = n_val1;
        send(-1, -1, 1'b0);
        settle();
        check_eq("t4_match_ack_slot", ack_slot1, 1'b1);
        check_eq("t4_match_valid_once", n_val1 - v1, 1);
        check_eq("t4_match_id", frame_id_1, {11'h124, 1'b0, 18'h0});
        consume("t4_consume_b");

        // Back-to-back frames with the output register full
        build(11'h111, 4'd1, 64'h1100_0000_0000_0000, 1'b0);
        send(-1, -1, 1'b0);
        build(11'h222, 4'd1, 64'h2200_0000_0000_0000, 1'b0);
        send(-1, -1, 1'b0);
        settle();
        check_eq("t5_valid", frame_valid, 1'b1);
        check_eq("t5_kept_id", frame_id, {11'h111, 1'b0, 18'h0});
        check_eq("t5_kept_data", frame_data, 64'h1100_0000_0000_0000);
        check_eq("t5_overrun", overrun, 1'b1);

        // Reset in the middle of the data field
        build(11'h333, 4'd4, 64'hDEAD_BEEF_0000_0000, 1'b0);
        send(-1, 25, 1'b0);
        check_eq("t6_cap_rst", cap_rst, 1'b1);
        check_eq("t6_cap_en", cap_en, 1'b0);
        check_eq("t6_cap_ack", cap_ack, 1'b0);
        check_eq("t6_valid", frame_valid, 1'b0);
        check_eq("t6_id", frame_id, 30'h0);
        check_eq("t6_data", frame_data, 64'h0);
        check_eq("t6_overrun", overrun, 1'b0);
        check_eq("t6_errs", {err_stuff, err_crc}, 2'b00);
        idle_bits(12);

        // Back-to-back again, consumer takes the first frame in the second's load cycle
        build(11'h111, 4'd1, 64'h1100_0000_0000_0000, 1'b0);
        send(-1, -1, 1'b0);
        build(11'h222, 4'd1, 64'h2200_0000_0000_0000, 1'b0);
        send(-1, -1, 1'b1);
        settle();
        check_eq("t7_valid", frame_valid, 1'b1);
        check_eq("t7_new_id", frame_id, {11'h222, 1'b0, 18'h0});
        check_eq("t7_new_data", frame_data, 64'h2200_0000_0000_0000);
        check_eq("t7_overrun", overrun, 1'b0);
        consume("t7_consume");

        // DLC field above 8 clamps to 8
        build(11'h7F0, 4'hF, 64'h0102_0304_0506_0708, 1'b0);
        send(-1, -1, 1'b0);
        settle();
        check_eq("t8_valid", frame_valid, 1'b1);
        check_eq("t8_id", frame_id, {11'h7F0, 1'b0, 18'h0});
        check_eq("t8_dlc_clamp", frame_dlc, 4'd8);
        check_eq("t8_data", frame_data, 64'h0102_0304_0506_0708);
        consume("t8_consume");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
